// File: rtl/network_pkg.sv
// Shared definitions for the Network block and its run sequencer.
//   NET_W   : width of a Network result word
//   state_t : sequencer state encoding
package network_pkg;

  localparam int unsigned NET_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_STALL = 2'd3
  } state_t;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO.
//   clk, reset          : clock, synchronous active-high reset
//   push, push_data     : write request and data (dropped when full without a pop)
//   pop                 : read request (ignored when empty)
//   rd_data             : head entry, valid while empty = 0
//   full, empty, level  : occupancy status
module result_fifo
  import network_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = NET_W,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_d;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next occupancy.
  always_comb begin
    level_d = level;
    if (do_push && !do_pop) begin
      level_d = level + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level - LW'(1);
    end
  end

  // Pointers and registered status; power-of-two depth wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  // Storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/network_sequencer.sv
// Self-timed run sequencer for the Network start/done/out interface.
//   clk, reset      : clock, synchronous active-high reset
//   go              : start a batch of RUNS inferences (sampled in IDLE only)
//   net_start       : level start to Network
//   net_done        : Network completion, rising edge marks a result
//   net_out         : Network result, valid in the done-edge cycle
//   busy            : sequencer not idle
//   batch_done      : one-cycle pulse after the final capture of a batch
//   timeout_err     : sticky watchdog flag, cleared by reset or accepted go
//   rd_en           : result pop request
//   rd_valid        : result FIFO non-empty
//   rd_data         : result FIFO head
//   level           : result FIFO occupancy
module network_sequencer
  import network_pkg::*;
#(
  parameter int unsigned RUNS    = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             net_start,
  input  logic             net_done,
  input  logic [NET_W-1:0] net_out,
  output logic             busy,
  output logic             batch_done,
  output logic             timeout_err,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [NET_W-1:0] rd_data,
  output logic [LW-1:0]    level
);

  localparam int unsigned RW = 8;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP + 1);

  state_t           state;
  state_t           state_d;
  logic [RW-1:0]    run_cnt;
  logic [RW-1:0]    run_cnt_d;
  logic [RW-1:0]    run_inc;
  logic [WW-1:0]    wd;
  logic [WW-1:0]    wd_d;
  logic [WW-1:0]    wd_inc;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_d;
  logic [NET_W-1:0] hold;
  logic [NET_W-1:0] hold_d;
  logic [NET_W-1:0] push_data;
  logic             done_q;
  logic             done_edge;
  logic             push;
  logic             can_push;
  logic             last_run;
  logic             terr_d;
  logic             bdone_d;
  logic             full;
  logic             empty;

  assign done_edge = net_done & ~done_q;
  // A same-cycle pop makes room even when the FIFO is full.
  assign can_push  = ~full | (rd_en & ~empty);
  assign run_inc   = run_cnt + RW'(1);
  assign wd_inc    = wd + WW'(1);
  assign last_run  = (run_inc == RW'(RUNS));
  assign rd_valid  = ~empty;

  // Next-state, capture and watchdog decisions.
  always_comb begin
    state_d   = state;
    run_cnt_d = run_cnt;
    wd_d      = wd;
    gap_d     = gap_cnt;
    hold_d    = hold;
    terr_d    = timeout_err;
    bdone_d   = 1'b0;
    push      = 1'b0;
    push_data = net_out;

    case (state)
      ST_IDLE: begin
        if (go) begin
          terr_d    = 1'b0;
          run_cnt_d = '0;
          wd_d      = '0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        if (done_edge) begin
          if (can_push) begin
            push      = 1'b1;
            run_cnt_d = run_inc;
            if (last_run) begin
              bdone_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end else begin
            hold_d  = net_out;
            state_d = ST_STALL;
          end
        end else if (wd_inc == WW'(TIMEOUT)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end

      ST_STALL: begin
        if (can_push) begin
          push      = 1'b1;
          push_data = hold;
          run_cnt_d = run_inc;
          if (last_run) begin
            bdone_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          wd_d    = '0;
          state_d = ST_RUN;
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      run_cnt     <= '0;
      wd          <= '0;
      gap_cnt     <= '0;
      hold        <= '0;
      done_q      <= 1'b0;
      timeout_err <= 1'b0;
      batch_done  <= 1'b0;
      net_start   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      run_cnt     <= run_cnt_d;
      wd          <= wd_d;
      gap_cnt     <= gap_d;
      hold        <= hold_d;
      done_q      <= net_done;
      timeout_err <= terr_d;
      batch_done  <= bdone_d;
      net_start   <= (state_d == ST_RUN);
      busy        <= (state_d != ST_IDLE);
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (NET_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

endmodule

// File: tb/tb_network_sequencer.sv
// Randomized bench for network_sequencer: a behavioural Network model drives
// the done/out side, and a queue-based expectation model predicts every output.
module tb_network_sequencer;
  import network_pkg::*;

  localparam int unsigned RUNS    = 6;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned GAP     = 2;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned LW      = $clog2(DEPTH + 1);

  localparam int NM_NORMAL = 0;
  localparam int NM_SILENT = 1;
  localparam int NM_STICKY = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic             net_start;
  logic             net_done;
  logic [NET_W-1:0] net_out;
  logic             busy;
  logic             batch_done;
  logic             timeout_err;
  logic             rd_en;
  logic             rd_valid;
  logic [NET_W-1:0] rd_data;
  logic [LW-1:0]    level;

  always #5 clk = ~clk;

  network_sequencer #(
    .RUNS    (RUNS),
    .DEPTH   (DEPTH),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .net_start   (net_start),
    .net_done    (net_done),
    .net_out     (net_out),
    .busy        (busy),
    .batch_done  (batch_done),
    .timeout_err (timeout_err),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .level       (level)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expectation model: what the sequencer should be doing after each edge.
  bit          m_busy  = 0;
  bit          m_start = 0;
  bit          m_stall = 0;
  bit          m_terr  = 0;
  bit          m_bdone = 0;
  bit          m_dq    = 0;
  int          m_low   = 0;
  int          m_runs  = 0;
  int          m_wd    = 0;
  logic [31:0] m_hold  = '0;
  logic [31:0] exp_q[$];

  // Network model and stimulus knobs.
  int          nm_mode     = NM_NORMAL;
  int          nm_lat_lo   = 2;
  int          nm_lat_hi   = 12;
  int          nm_cnt      = 0;
  int          nm_hold     = 0;
  bit          nm_armed    = 0;
  bit          nm_prev     = 0;
  int unsigned rd_pct      = 50;
  int unsigned go_pct      = 10;
  bit          go_req      = 0;
  bit          force_pop   = 0;
  bit          pop_on_done = 0;

  task automatic model_update();
    bit          pop;
    bit          space;
    bit          push;
    logic [31:0] pv;
    if (reset) begin
      m_busy = 0; m_start = 0; m_stall = 0; m_terr = 0; m_bdone = 0;
      m_low = 0; m_runs = 0; m_wd = 0; m_dq = 0;
      exp_q.delete();
      return;
    end
    pop   = rd_en && (exp_q.size() > 0);
    space = (exp_q.size() < int'(DEPTH)) || pop;
    push  = 0;
    pv    = '0;
    m_bdone = 0;
    if (!m_busy) begin
      if (go) begin
        m_terr = 0; m_runs = 0; m_busy = 1; m_start = 1; m_wd = 0;
      end
    end else if (m_start) begin
      if (net_done && !m_dq) begin
        m_start = 0;
        if (space) begin
          push = 1; pv = net_out;
        end else begin
          m_hold = net_out; m_stall = 1;
        end
      end else begin
        m_wd++;
        if (m_wd == int'(TIMEOUT)) begin
          m_terr = 1; m_busy = 0; m_start = 0;
        end
      end
    end else if (m_stall) begin
      if (space) begin
        push = 1; pv = m_hold; m_stall = 0;
      end
    end else begin
      m_low--;
      if (m_low == 0) begin
        m_start = 1; m_wd = 0;
      end
    end
    if (push) begin
      m_runs++;
      if (m_runs == int'(RUNS)) begin
        m_bdone = 1; m_busy = 0;
      end else begin
        m_low = int'(GAP);
      end
    end
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(pv);
    m_dq = net_done;
  endtask

  task automatic compare_outputs();
    check("net_start",   32'(net_start),   32'(m_start));
    check("busy",        32'(busy),        32'(m_busy));
    check("batch_done",  32'(batch_done),  32'(m_bdone));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
    check("level",       32'(level),       exp_q.size());
    check("rd_valid",    32'(rd_valid),    32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("rd_data", rd_data, exp_q[0]);
  endtask

  task automatic drive_inputs();
    logic was_high;
    bit   raised;
    was_high = net_done;
    raised   = 0;
    if (nm_hold > 0) begin
      nm_hold--;
      if (nm_hold == 0) net_done = 1'b0;
    end
    if (net_start && !nm_prev) begin
      nm_armed = 1;
      nm_cnt   = $urandom_range(nm_lat_hi, nm_lat_lo);
    end else if (!net_start) begin
      nm_armed = 0;
    end else if (nm_armed && nm_cnt > 0) begin
      nm_cnt--;
    end
    // A new result needs done to have been low for at least one cycle.
    if (nm_armed && nm_cnt == 0 && nm_mode != NM_SILENT && !was_high && !net_done) begin
      net_done = 1'b1;
      net_out  = $urandom;
      nm_hold  = (nm_mode == NM_STICKY) ? int'(GAP) + 4 : int'($urandom_range(2, 1));
      nm_armed = 0;
      raised   = 1;
    end
    nm_prev = net_start;

    if (force_pop) begin
      rd_en = 1'b1; force_pop = 0;
    end else if (pop_on_done && raised && exp_q.size() == int'(DEPTH)) begin
      rd_en = 1'b1;
    end else begin
      rd_en = ($urandom_range(99, 0) < rd_pct);
    end

    if (go_req) begin
      go = 1'b1; go_req = 0;
    end else begin
      go = m_busy && ($urandom_range(99, 0) < go_pct);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    compare_outputs();
    drive_inputs();
  endtask

  task automatic start_batch();
    go_req = 1;
    step();
    step();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      step();
      n++;
    end
    if (m_busy) check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rd_pct = 100;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drained", 32'(level), 32'd0);
  endtask

  initial begin
    int hi;
    int n;
    int pulses;
    reset   = 1'b1;
    go      = 1'b0;
    net_done = 1'b0;
    net_out = '0;
    rd_en   = 1'b0;
    repeat (3) step();
    check("rst_net_start", 32'(net_start), 32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    reset = 1'b0;
    step();

    // Basic batches with fixed and random Network latency, random reads.
    nm_lat_lo = 20; nm_lat_hi = 20; rd_pct = 50;
    start_batch();
    pulses = 0;
    n = 0;
    while (m_busy && n < 1000) begin
      step();
      if (batch_done === 1'b1) pulses++;
      n++;
    end
    step();
    if (batch_done === 1'b1) pulses++;
    check("bdone_pulses", pulses, 1);
    nm_lat_lo = 2; nm_lat_hi = 12;
    repeat (3) begin
      start_batch();
      run_until_idle(1000);
      repeat (3) step();
    end
    drain(50);

    // Backpressure: no reads until the sequencer stalls on a full FIFO.
    rd_pct = 0; go_pct = 0;
    start_batch();
    repeat (120) step();
    check("bp_level", 32'(level),     DEPTH);
    check("bp_start", 32'(net_start), 32'd0);
    check("bp_busy",  32'(busy),      32'd1);
    force_pop = 1;
    repeat (4) step();
    check("bp_release", 32'(level), DEPTH);
    rd_pct = 30;
    run_until_idle(1000);
    drain(50);

    // Watchdog: Network never answers.
    nm_mode = NM_SILENT; rd_pct = 0;
    go_req = 1;
    step();
    hi = 0;
    n = 0;
    do begin
      step();
      if (net_start === 1'b1) hi++;
      n++;
    end while (m_busy && n < 500);
    check("wd_len",   hi, TIMEOUT);
    check("to_flag",  32'(timeout_err), 32'd1);
    repeat (3) step();
    nm_mode = NM_NORMAL; rd_pct = 60; go_pct = 10;
    start_batch();
    check("to_clear", 32'(timeout_err), 32'd0);
    run_until_idle(1000);
    drain(50);

    // Stale done held high across the gap.
    nm_mode = NM_STICKY; rd_pct = 100;
    start_batch();
    run_until_idle(2000);
    drain(50);
    nm_mode = NM_NORMAL;

    // Reset during the second run.
    rd_pct = 0;
    start_batch();
    n = 0;
    while (!(m_runs == 1 && m_start) && n < 500) begin
      step();
      n++;
    end
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_start", 32'(net_start), 32'd0);
    check("mid_rst_level", 32'(level),     32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    repeat (5) step();

    // Full FIFO with a pop in the capture cycle: no stall, order kept.
    pop_on_done = 1; rd_pct = 0; go_pct = 0;
    start_batch();
    run_until_idle(1000);
    check("full_pop_level", 32'(level), DEPTH);
    pop_on_done = 0;
    drain(50);

    // Random mix to finish.
    go_pct = 15;
    repeat (4) begin
      rd_pct = $urandom_range(80, 10);
      start_batch();
      run_until_idle(2000);
      repeat (2) step();
    end
    drain(50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
